// File: rtl/flexdpe_pkg.sv
// Shared definitions for the Flex-DPE ingress slice.
//   state_e     : ingress sequencer FSM state; the encoding is the o_state value
//   beat_width  : width of one buffered beat {data, dest, stationary}
package flexdpe_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  localparam int unsigned DEF_IN_DATA_TYPE = 16;
  localparam int unsigned DEF_NUM_PES      = 32;
  localparam int unsigned DEF_LOG2_PES     = 5;
  localparam int unsigned DEF_BEAT_W       =
    DEF_NUM_PES * DEF_IN_DATA_TYPE + DEF_NUM_PES * DEF_LOG2_PES + 1;

  function automatic int unsigned beat_width(input int unsigned num_pes,
                                             input int unsigned in_w,
                                             input int unsigned log2_pes);
    return num_pes * in_w + num_pes * log2_pes + 1;
  endfunction

endpackage

// File: rtl/dpe_sync_fifo.sv
// Generic synchronous FIFO with an occupancy count.
//   clk, rst  : clock, synchronous active-high reset (empties the FIFO)
//   push_i    : write wdata_i (ignored when full)
//   pop_i     : advance the head (ignored when empty)
//   rdata_o   : head entry
//   count_o   : occupancy, 0..DEPTH
//   empty_o   : count_o == 0
module dpe_sync_fifo
  import flexdpe_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [WIDTH-1:0]      wdata_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic [LOG2_DEPTH:0]   count_o,
  output logic                  empty_o
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG2_DEPTH:0]   count_q;
  logic                  full, push_ok, pop_ok;

  assign full    = (count_q == (LOG2_DEPTH+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i && !full;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage carries no reset; emptiness is defined by the pointers/count.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/dpe_ingress_sequencer.sv
// Flex-DPE ingress sequencer: DEPTH-entry back-pressured buffer in front of
// the xbar / multiplier chain, sequencing one tile as stationary beats,
// then streaming beats, then a drain of the buffer.
//   cfg_*            : tile configuration, latched on cfg_start in IDLE
//   i_data_valid/o_ready, i_data_bus, i_dest_bus, i_stationary : upstream beat
//   o_data_valid/i_ds_ready, o_data_bus, o_dest_bus, o_stationary : head beat
//   o_vn_seperator   : separator latched for the current tile
//   o_state          : FSM state (IDLE=0, LOAD=1, STREAM=2, DRAIN=3)
//   o_done           : one-cycle pulse on return to IDLE after a drain
//   o_err            : sticky flag for beats dropped on a tag mismatch
module dpe_ingress_sequencer
  import flexdpe_pkg::*;
#(
  parameter int unsigned IN_DATA_TYPE = 16,
  parameter int unsigned NUM_PES      = 32,
  parameter int unsigned LOG2_PES     = 5,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned LOG2_DEPTH   = 2,
  parameter int unsigned ROW_W        = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_start,
  input  logic [ROW_W-1:0]               cfg_stat_rows,
  input  logic [ROW_W-1:0]               cfg_stream_rows,
  input  logic [NUM_PES*LOG2_PES-1:0]    cfg_vn_seperator,
  input  logic                           i_data_valid,
  output logic                           o_ready,
  input  logic [NUM_PES*IN_DATA_TYPE-1:0] i_data_bus,
  input  logic [NUM_PES*LOG2_PES-1:0]    i_dest_bus,
  input  logic                           i_stationary,
  input  logic                           i_ds_ready,
  output logic                           o_data_valid,
  output logic [NUM_PES*IN_DATA_TYPE-1:0] o_data_bus,
  output logic [NUM_PES*LOG2_PES-1:0]    o_dest_bus,
  output logic                           o_stationary,
  output logic [NUM_PES*LOG2_PES-1:0]    o_vn_seperator,
  output logic [1:0]                     o_state,
  output logic                           o_done,
  output logic                           o_err
);

  localparam int unsigned BEAT_W = beat_width(NUM_PES, IN_DATA_TYPE, LOG2_PES);

  state_e                        state_q, state_d;
  logic [ROW_W-1:0]              stat_rows_q, stat_rows_d;
  logic [ROW_W-1:0]              stream_rows_q, stream_rows_d;
  logic [ROW_W-1:0]              load_cnt_q, load_cnt_d;
  logic [ROW_W-1:0]              stream_cnt_q, stream_cnt_d;
  logic [NUM_PES*LOG2_PES-1:0]   sep_q, sep_d;
  logic                          err_q, err_d;
  logic                          done_q, done_d;

  logic                          push, pop, accept;
  logic                          fifo_empty, fifo_full;
  logic [LOG2_DEPTH:0]           fifo_count;
  logic [BEAT_W-1:0]             head;

  assign fifo_full = (fifo_count == (LOG2_DEPTH+1)'(DEPTH));
  assign o_ready   = ((state_q == ST_LOAD) || (state_q == ST_STREAM)) && !fifo_full;
  assign accept    = i_data_valid && o_ready;
  assign pop       = !fifo_empty && i_ds_ready;

  dpe_sync_fifo #(
    .WIDTH      (BEAT_W),
    .DEPTH      (DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({i_data_bus, i_dest_bus, i_stationary}),
    .rdata_o (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Head outputs are forced to zero while empty so stale storage never leaks.
  assign o_data_valid   = !fifo_empty;
  assign {o_data_bus, o_dest_bus, o_stationary} = fifo_empty ? '0 : head;
  assign o_vn_seperator = sep_q;
  assign o_state        = state_q;
  assign o_done         = done_q;
  assign o_err          = err_q;

  always_comb begin
    state_d       = state_q;
    stat_rows_d   = stat_rows_q;
    stream_rows_d = stream_rows_q;
    load_cnt_d    = load_cnt_q;
    stream_cnt_d  = stream_cnt_q;
    sep_d         = sep_q;
    err_d         = err_q;
    done_d        = 1'b0;
    push          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          stat_rows_d   = cfg_stat_rows;
          stream_rows_d = cfg_stream_rows;
          sep_d         = cfg_vn_seperator;
          load_cnt_d    = '0;
          stream_cnt_d  = '0;
          err_d         = 1'b0;
          if (cfg_stat_rows != '0)        state_d = ST_LOAD;
          else if (cfg_stream_rows != '0) state_d = ST_STREAM;
          else                            state_d = ST_DRAIN;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          if (i_stationary) begin
            push       = 1'b1;
            load_cnt_d = load_cnt_q + 1'b1;
            if (load_cnt_d == stat_rows_q)
              state_d = (stream_rows_q != '0) ? ST_STREAM : ST_DRAIN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_STREAM: begin
        if (accept) begin
          if (!i_stationary) begin
            push         = 1'b1;
            stream_cnt_d = stream_cnt_q + 1'b1;
            if (stream_cnt_d == stream_rows_q) state_d = ST_DRAIN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      stat_rows_q   <= '0;
      stream_rows_q <= '0;
      load_cnt_q    <= '0;
      stream_cnt_q  <= '0;
      sep_q         <= '0;
      err_q         <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      stat_rows_q   <= stat_rows_d;
      stream_rows_q <= stream_rows_d;
      load_cnt_q    <= load_cnt_d;
      stream_cnt_q  <= stream_cnt_d;
      sep_q         <= sep_d;
      err_q         <= err_d;
      done_q        <= done_d;
    end
  end

endmodule

// File: tb/tb_dpe_ingress_sequencer.sv
// Directed bench for dpe_ingress_sequencer at default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_dpe_ingress_sequencer;

  localparam int unsigned IN_DATA_TYPE = 16;
  localparam int unsigned NUM_PES      = 32;
  localparam int unsigned LOG2_PES     = 5;
  localparam int unsigned DEPTH        = 4;
  localparam int unsigned LOG2_DEPTH   = 2;
  localparam int unsigned ROW_W        = 16;

  logic                            clk = 1'b0;
  logic                            rst;
  logic                            cfg_start;
  logic [ROW_W-1:0]                cfg_stat_rows, cfg_stream_rows;
  logic [NUM_PES*LOG2_PES-1:0]     cfg_vn_seperator;
  logic                            i_data_valid, o_ready;
  logic [NUM_PES*IN_DATA_TYPE-1:0] i_data_bus, o_data_bus;
  logic [NUM_PES*LOG2_PES-1:0]     i_dest_bus, o_dest_bus, o_vn_seperator;
  logic                            i_stationary, i_ds_ready;
  logic                            o_data_valid, o_stationary;
  logic [1:0]                      o_state;
  logic                            o_done, o_err;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  dpe_ingress_sequencer #(
    .IN_DATA_TYPE (IN_DATA_TYPE),
    .NUM_PES      (NUM_PES),
    .LOG2_PES     (LOG2_PES),
    .DEPTH        (DEPTH),
    .LOG2_DEPTH   (LOG2_DEPTH),
    .ROW_W        (ROW_W)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_start        (cfg_start),
    .cfg_stat_rows    (cfg_stat_rows),
    .cfg_stream_rows  (cfg_stream_rows),
    .cfg_vn_seperator (cfg_vn_seperator),
    .i_data_valid     (i_data_valid),
    .o_ready          (o_ready),
    .i_data_bus       (i_data_bus),
    .i_dest_bus       (i_dest_bus),
    .i_stationary     (i_stationary),
    .i_ds_ready       (i_ds_ready),
    .o_data_valid     (o_data_valid),
    .o_data_bus       (o_data_bus),
    .o_dest_bus       (o_dest_bus),
    .o_stationary     (o_stationary),
    .o_vn_seperator   (o_vn_seperator),
    .o_state          (o_state),
    .o_done           (o_done),
    .o_err            (o_err)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [15:0] val, input logic stat);
    i_data_valid = 1'b1;
    i_data_bus   = {NUM_PES{val}};
    i_dest_bus   = '0;
    i_stationary = stat;
  endtask

  task automatic start_tile(input logic [15:0] srows, input logic [15:0] trows,
                            input logic [63:0] sep);
    cfg_start        = 1'b1;
    cfg_stat_rows    = srows;
    cfg_stream_rows  = trows;
    cfg_vn_seperator = '0;
    cfg_vn_seperator[63:0] = sep;
    step();
    cfg_start = 1'b0;
  endtask

  localparam logic [63:0] SEP_A = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] SEP_B = 64'h0FED_CBA9_8765_4321;
  localparam logic [63:0] SEP_C = 64'h1111_2222_3333_4444;

  initial begin
    int unsigned acc;
    logic [15:0] exp_data [5];
    logic        exp_tag  [5];
    exp_data = '{16'h1, 16'h2, 16'h3, 16'h4, 16'h5};
    exp_tag  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; cfg_start = 1'b0; cfg_stat_rows = '0; cfg_stream_rows = '0;
    cfg_vn_seperator = '0; i_data_valid = 1'b0; i_data_bus = '0; i_dest_bus = '0;
    i_stationary = 1'b0; i_ds_ready = 1'b1;
    step(); step();
    rst = 1'b0;

    // reset state
    check_vec("rst_state", 64'(o_state), 64'd0);
    check_vec("rst_ready", 64'(o_ready), 64'd0);
    check_vec("rst_valid", 64'(o_data_valid), 64'd0);
    check_vec("rst_done",  64'(o_done), 64'd0);
    check_vec("rst_err",   64'(o_err), 64'd0);
    check_vec("rst_sep",   o_vn_seperator[63:0], 64'd0);

    // basic tile: 2 stationary + 3 streaming, downstream always ready
    start_tile(16'd2, 16'd3, SEP_A);
    check_vec("t1_state_load", 64'(o_state), 64'd1);
    check_vec("t1_ready", 64'(o_ready), 64'd1);
    check_vec("t1_sep", o_vn_seperator[63:0], SEP_A);
    for (int i = 0; i < 5; i++) begin
      set_beat(exp_data[i], exp_tag[i]);
      step();
      check_vec($sformatf("t1_valid%0d", i), 64'(o_data_valid), 64'd1);
      check_vec($sformatf("t1_data%0d", i), 64'(o_data_bus[15:0]), 64'(exp_data[i]));
      check_vec($sformatf("t1_tag%0d", i), 64'(o_stationary), 64'(exp_tag[i]));
      if (i == 1) check_vec("t1_state_stream", 64'(o_state), 64'd2);
    end
    check_vec("t1_state_drain", 64'(o_state), 64'd3);
    check_vec("t1_ready_drain", 64'(o_ready), 64'd0);
    i_data_valid = 1'b0;
    step();
    check_vec("t1_valid_off", 64'(o_data_valid), 64'd0);
    check_vec("t1_done_early", 64'(o_done), 64'd0);
    step();
    check_vec("t1_state_idle", 64'(o_state), 64'd0);
    check_vec("t1_done", 64'(o_done), 64'd1);
    check_vec("t1_err", 64'(o_err), 64'd0);
    step();
    check_vec("t1_done_once", 64'(o_done), 64'd0);

    // backpressure: 6-beat streaming tile, downstream stalled
    i_ds_ready = 1'b0;
    start_tile(16'd0, 16'd6, SEP_B);
    check_vec("t2_state_stream", 64'(o_state), 64'd2);
    acc = 0;
    set_beat(16'h10, 1'b0);
    for (int i = 0; i < 6; i++) begin
      logic take;
      take = o_ready;
      step();
      if (take) acc++;
      set_beat(16'(16'h10 + acc), 1'b0);
    end
    check_vec("t2_accepted", 64'(acc), 64'd4);
    check_vec("t2_ready_full", 64'(o_ready), 64'd0);
    check_vec("t2_head0", 64'(o_data_bus[15:0]), 64'h10);
    i_data_valid = 1'b0;

    // start while streaming must be ignored
    start_tile(16'd5, 16'd2, SEP_C);
    check_vec("t2_ign_sep", o_vn_seperator[63:0], SEP_B);
    check_vec("t2_ign_state", 64'(o_state), 64'd2);

    i_ds_ready = 1'b1;
    step();
    check_vec("t2_ready_back", 64'(o_ready), 64'd1);
    check_vec("t2_head1", 64'(o_data_bus[15:0]), 64'h11);
    step();
    check_vec("t2_head2", 64'(o_data_bus[15:0]), 64'h12);
    step();
    check_vec("t2_head3", 64'(o_data_bus[15:0]), 64'h13);
    step();
    check_vec("t2_empty", 64'(o_data_valid), 64'd0);
    set_beat(16'h14, 1'b0);
    step();
    check_vec("t2_state_5th", 64'(o_state), 64'd2);
    check_vec("t2_head4", 64'(o_data_bus[15:0]), 64'h14);
    set_beat(16'h15, 1'b0);
    step();
    check_vec("t2_state_drain", 64'(o_state), 64'd3);
    check_vec("t2_head5", 64'(o_data_bus[15:0]), 64'h15);
    i_data_valid = 1'b0;
    step();
    step();
    check_vec("t2_state_idle", 64'(o_state), 64'd0);
    check_vec("t2_done", 64'(o_done), 64'd1);

    // tag mismatch in LOAD
    start_tile(16'd1, 16'd1, SEP_A);
    set_beat(16'h20, 1'b0);
    step();
    check_vec("t3_err", 64'(o_err), 64'd1);
    check_vec("t3_dropped", 64'(o_data_valid), 64'd0);
    check_vec("t3_state_load", 64'(o_state), 64'd1);
    set_beat(16'h21, 1'b1);
    step();
    check_vec("t3_state_stream", 64'(o_state), 64'd2);
    check_vec("t3_head", 64'(o_data_bus[15:0]), 64'h21);
    set_beat(16'h22, 1'b0);
    step();
    check_vec("t3_state_drain", 64'(o_state), 64'd3);
    i_data_valid = 1'b0;
    step();
    step();
    check_vec("t3_done", 64'(o_done), 64'd1);
    check_vec("t3_err_sticky", 64'(o_err), 64'd1);

    // zero-length tile; start also clears the sticky error
    start_tile(16'd0, 16'd0, SEP_C);
    check_vec("t4_state_drain", 64'(o_state), 64'd3);
    check_vec("t4_err_clr", 64'(o_err), 64'd0);
    check_vec("t4_ready", 64'(o_ready), 64'd0);
    step();
    check_vec("t4_state_idle", 64'(o_state), 64'd0);
    check_vec("t4_done", 64'(o_done), 64'd1);
    check_vec("t4_ready_idle", 64'(o_ready), 64'd0);

    // reset mid-STREAM with 3 beats buffered
    i_ds_ready = 1'b0;
    start_tile(16'd0, 16'd8, SEP_C);
    for (int i = 0; i < 3; i++) begin
      set_beat(16'(16'h30 + i), 1'b0);
      step();
    end
    i_data_valid = 1'b0;
    check_vec("t5_buffered", 64'(dut.fifo_count), 64'd3);
    rst = 1'b1;
    step();
    check_vec("t5_valid", 64'(o_data_valid), 64'd0);
    check_vec("t5_state", 64'(o_state), 64'd0);
    check_vec("t5_done", 64'(o_done), 64'd0);
    check_vec("t5_sep", o_vn_seperator[63:0], 64'd0);
    rst = 1'b0;
    step();
    check_vec("t5_done_after", 64'(o_done), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
